// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int STOP_TICKS_1   = 16;
  localparam int STOP_TICKS_1P5 = 24;
  localparam int STOP_TICKS_2   = 32;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    WLS_5 = 2'b00,
    WLS_6 = 2'b01,
    WLS_7 = 2'b10,
    WLS_8 = 2'b11
  } wls_t;

  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
  } tx_cfg_t;

  // Stop constants are for the default rate; rescale them for other oversample ratios.
  function automatic int stop_ticks(int oversample, logic stb, logic [1:0] wls);
    if (!stb)
      return STOP_TICKS_1 * oversample / OVERSAMPLE_DEF;
    else if (wls == WLS_5)
      return STOP_TICKS_1P5 * oversample / OVERSAMPLE_DEF;
    else
      return STOP_TICKS_2 * oversample / OVERSAMPLE_DEF;
  endfunction

  function automatic logic parity_out(logic acc, logic eps, logic sp);
    if (sp)
      return ~eps;
    return eps ? acc : ~acc;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops bytes from a TX FIFO and serialises
// start, data (LSB first), optional parity and stop bits onto tx.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_pulse,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_pop,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       bc,
  output logic       tx,
  output logic       busy,
  output logic       temt
);

  localparam int TICK_W = $clog2(2 * OVERSAMPLE);
  localparam logic [TICK_W-1:0] BIT_LAST = TICK_W'(OVERSAMPLE - 1);

  tx_state_t         state, state_nxt;
  tx_cfg_t           cfg;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] stop_last;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              par_acc;
  logic              tx_q, tx_nxt;
  logic              bit_done, stop_done, unit_done, last_data, load;

  assign stop_last = TICK_W'(stop_ticks(OVERSAMPLE, cfg.stb, cfg.wls) - 1);
  assign bit_done  = baud_pulse && (tick_cnt == BIT_LAST);
  assign stop_done = baud_pulse && (tick_cnt == stop_last);
  assign unit_done = (state == TX_STOP) ? stop_done : bit_done;
  assign last_data = (bit_cnt == ({1'b0, cfg.wls} + 3'd4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= TX_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:   if (!fifo_empty) state_nxt = TX_START;
      TX_START:  if (bit_done) state_nxt = TX_DATA;
      TX_DATA:   if (bit_done && last_data) state_nxt = cfg.pen ? TX_PARITY : TX_STOP;
      TX_PARITY: if (bit_done) state_nxt = TX_STOP;
      TX_STOP:   if (stop_done) state_nxt = fifo_empty ? TX_IDLE : TX_START;
      default:   state_nxt = TX_IDLE;
    endcase
  end

  // tx is computed from the next state so the registered line changes on the same edge as the FSM.
  always_comb begin
    load   = 1'b0;
    tx_nxt = 1'b1;
    case (state)
      TX_IDLE: load = !fifo_empty;
      TX_STOP: load = stop_done && !fifo_empty;
      default: load = 1'b0;
    endcase
    case (state_nxt)
      TX_START:  tx_nxt = 1'b0;
      TX_DATA:   tx_nxt = (state == TX_DATA && bit_done) ? shreg[1] : shreg[0];
      TX_PARITY: tx_nxt = parity_out(par_acc ^ ((state == TX_DATA) ? shreg[0] : 1'b0),
                                     cfg.eps, cfg.sp);
      default:   tx_nxt = 1'b1;
    endcase
  end

  assign fifo_pop = rst_n && load;
  assign busy     = (state != TX_IDLE);
  assign temt     = (state == TX_IDLE) && fifo_empty;
  assign tx       = tx_q && !bc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg      <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_q <= tx_nxt;
      if (load) begin
        shreg    <= fifo_dout;
        cfg      <= '{wls: wls, stb: stb, pen: pen, eps: eps, sp: sp};
        tick_cnt <= '0;
        bit_cnt  <= '0;
        par_acc  <= 1'b0;
      end else if (state != TX_IDLE && baud_pulse) begin
        if (unit_done) begin
          tick_cnt <= '0;
          if (state == TX_DATA) begin
            shreg   <= shreg >> 1;
            par_acc <= par_acc ^ shreg[0];
            bit_cnt <= last_data ? 3'd0 : bit_cnt + 3'd1;
          end
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frame table, multi-cycle
// corner sequences and a randomized run against a tick-level line model.
module tb_uart_tx_ctrl;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_pulse = 1'b0;
  logic       bc = 1'b0;
  logic       stb = 1'b0, pen = 1'b0, eps = 1'b0, sp = 1'b0;
  logic [1:0] wls = 2'b11;
  logic       fifo_empty, fifo_pop, tx, busy, temt;
  logic [7:0] fifo_dout;

  logic [7:0] fifo_mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  bit         exp_q[$];

  logic       bp_s, pop_s, empty_s, rst_s, stb_s, pen_s, eps_s, sp_s;
  logic [1:0] wls_s;
  logic [7:0] dout_s;

  typedef struct {
    logic [7:0] data;
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
    logic [8:0] exp_bits;
    int         exp_len;
    int         exp_stop;
  } vec_t;

  vec_t vecs[9];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_dout  = fifo_mem[rd_ptr[7:0]];

  uart_tx_ctrl #(.OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_pulse (baud_pulse),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_pop   (fifo_pop),
    .wls        (wls),
    .stb        (stb),
    .pen        (pen),
    .eps        (eps),
    .sp         (sp),
    .bc         (bc),
    .tx         (tx),
    .busy       (busy),
    .temt       (temt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  // Line model: one queue entry per baud tick holding the expected tx level.
  task automatic add_frame(input logic [7:0] d, input logic [1:0] w, input logic s,
                           input logic p, input logic e, input logic spv);
    int n = 5 + int'(w);
    int ones = 0;
    int stop_n;
    bit pb;
    for (int i = 0; i < OS; i++) exp_q.push_back(1'b0);
    for (int b = 0; b < n; b++) begin
      if (d[b]) ones++;
      for (int i = 0; i < OS; i++) exp_q.push_back(d[b]);
    end
    if (p) begin
      if (spv) pb = !e;
      else if (e) pb = (ones % 2 == 1);
      else pb = (ones % 2 == 0);
      for (int i = 0; i < OS; i++) exp_q.push_back(pb);
    end
    stop_n = s ? ((w == 2'b00) ? (3 * OS) / 2 : 2 * OS) : OS;
    for (int i = 0; i < stop_n; i++) exp_q.push_back(1'b1);
  endtask

  always begin
    @(posedge clk);
    bp_s = baud_pulse; pop_s = fifo_pop; empty_s = fifo_empty; rst_s = rst_n;
    dout_s = fifo_dout; wls_s = wls; stb_s = stb; pen_s = pen; eps_s = eps; sp_s = sp;
    #1;
    if (!rst_s || !rst_n) begin
      exp_q.delete();
    end else begin
      checkOutput("fifo_pop", int'(pop_s),
                  int'(!empty_s && (exp_q.size() == 0 || (exp_q.size() == 1 && bp_s))));
      checkOutput("pop_while_empty", int'(pop_s & empty_s), 0);
      if (bp_s && exp_q.size() > 0) exp_q.delete(0);
      if (pop_s) begin
        add_frame(dout_s, wls_s, stb_s, pen_s, eps_s, sp_s);
        rd_ptr++;
      end
      #1;
      if (rst_n) begin
        checkOutput("tx", int'(tx), bc ? 0 : ((exp_q.size() > 0) ? int'(exp_q[0]) : 1));
        checkOutput("busy", int'(busy), int'(exp_q.size() > 0));
        checkOutput("temt", int'(temt), int'(exp_q.size() == 0 && fifo_empty));
      end
    end
  end

  task automatic wait_busy(input logic level, input int limit, input string name);
    int n = 0;
    while (busy !== level && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, int'(busy), int'(level));
  endtask

  function automatic int sample_at(input bit q[$], input int i);
    return (i < q.size()) ? int'(q[i]) : 2;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bit samples[$];
    int n = 0;
    int nbad = 0;
    int lvl;
    @(negedge clk);
    wls = v.wls; stb = v.stb; pen = v.pen; eps = v.eps; sp = v.sp;
    baud_pulse = 1'b1;
    push_byte(v.data);
    wait_busy(1'b1, 50, "vec_frame_start");
    while (busy && n < 1000) begin
      samples.push_back(tx);
      @(posedge clk); #1;
      n++;
    end
    checkOutput("vec_frame_len", samples.size(), OS * (1 + v.exp_len) + v.exp_stop);
    for (int i = 0; i < samples.size(); i++) begin
      if (i < OS) lvl = 0;
      else if (i < OS * (1 + v.exp_len)) lvl = int'(v.exp_bits[(i / OS) - 1]);
      else lvl = 1;
      if (int'(samples[i]) != lvl) nbad++;
    end
    checkOutput("vec_frame_levels_bad", nbad, 0);
    checkOutput("vec_temt_after", int'(temt), 1);
  endtask

  initial begin
    bit samples[$];
    int t0, p0, n;

    vecs[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0A5, 8, 16};
    vecs[1] = '{8'h3B, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 9'h07B, 7, 16};
    vecs[2] = '{8'h15, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 9'h015, 5, 24};
    vecs[3] = '{8'h6C, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 9'h06C, 7, 32};
    vecs[4] = '{8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 9'h100, 9, 16};
    vecs[5] = '{8'hFF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 9'h1FF, 9, 16};
    vecs[6] = '{8'h1F, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 9'h01F, 6, 16};
    vecs[7] = '{8'h03, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 9'h103, 9, 16};
    vecs[8] = '{8'hC1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 9'h041, 7, 32};

    $display("[TB] reset checks");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_tx", int'(tx), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_pop", int'(fifo_pop), 0);
    checkOutput("reset_temt", int'(temt), 1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed frame table");
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    $display("[TB] back-to-back frames");
    @(negedge clk);
    wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; sp = 1'b0; baud_pulse = 1'b1;
    p0 = rd_ptr;
    push_byte(8'h01);
    push_byte(8'hFF);
    wait_busy(1'b1, 50, "b2b_start");
    n = 0;
    while (busy && n < 1000) begin
      samples.push_back(tx);
      @(posedge clk); #1;
      n++;
    end
    checkOutput("b2b_busy_len", samples.size(), 2 * OS * 10);
    checkOutput("b2b_pops", rd_ptr - p0, 2);
    checkOutput("b2b_last_stop", sample_at(samples, OS * 10 - 1), 1);
    checkOutput("b2b_second_start", sample_at(samples, OS * 10), 0);
    checkOutput("b2b_second_data0", sample_at(samples, OS * 11), 1);

    $display("[TB] break control mid-data");
    @(negedge clk);
    push_byte(8'hA5);
    wait_busy(1'b1, 50, "bc_frame_start");
    t0 = cyc;
    repeat (20) begin @(posedge clk); #1; end
    @(negedge clk);
    bc = 1'b1;
    #1;
    checkOutput("bc_forces_tx", int'(tx), 0);
    checkOutput("bc_keeps_busy", int'(busy), 1);
    repeat (40) @(negedge clk);
    bc = 1'b0;
    #1;
    checkOutput("bc_release_tx", int'(tx), 1);
    wait_busy(1'b0, 400, "bc_frame_end");
    checkOutput("bc_frame_len", cyc - t0, OS * 10);

    $display("[TB] reset mid-data");
    @(negedge clk);
    push_byte(8'h5A);
    push_byte(8'hC3);
    wait_busy(1'b1, 50, "rst_frame_start");
    repeat (40) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_tx", int'(tx), 1);
    checkOutput("rst_async_busy", int'(busy), 0);
    checkOutput("rst_async_pop", int'(fifo_pop), 0);
    p0 = rd_ptr;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("rst_resume_busy", int'(busy), 1);
    checkOutput("rst_resume_pops", rd_ptr - p0, 1);
    wait_busy(1'b0, 400, "rst_resume_end");
    checkOutput("rst_no_extra_pop", rd_ptr - p0, 1);
    checkOutput("rst_temt", int'(temt), 1);

    $display("[TB] randomized run");
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      baud_pulse = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        wls = 2'($urandom_range(0, 3));
        stb = 1'($urandom_range(0, 1));
        pen = 1'($urandom_range(0, 1));
        eps = 1'($urandom_range(0, 1));
        sp  = 1'($urandom_range(0, 1));
      end
      bc = ($urandom_range(0, 199) == 0);
      if ((wr_ptr - rd_ptr) < 2 && $urandom_range(0, 299) == 0) push_byte(8'($urandom));
    end
    @(negedge clk);
    bc = 1'b0;
    baud_pulse = 1'b1;
    n = 0;
    while ((busy || !fifo_empty) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_temt", int'(temt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: OVERSAMPLE, default 16, baud_pulse ticks per bit time.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 baud_pulse  input  1  one-clk strobe at OVERSAMPLE x baud rate.
REQ-005 fifo_empty  input  1  TX FIFO empty flag.
REQ-006 fifo_dout  input  8  TX FIFO head byte, combinationally valid while fifo_empty=0.
REQ-007 fifo_pop  output  1  one-clk pop strobe to TX FIFO.
REQ-008 wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-009 stb  input  1  stop bits: 0=1; 1=1.5 if wls=00, else 2.
REQ-010 pen  input  1  parity enable.
REQ-011 eps  input  1  even parity select.
REQ-012 sp  input  1  stick parity.
REQ-013 bc  input  1  break control.
REQ-014 tx  output  1  serial line; idle high.
REQ-015 busy  output  1  frame in progress (state != IDLE).
REQ-016 temt  output  1  transmitter empty: state=IDLE and fifo_empty=1.

Function
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP; the encoding SHALL be defined in the shared package.
REQ-018 IDLE with fifo_empty=0: assert fifo_pop for one clk, latch fifo_dout, wls, stb, pen, eps and sp in the same clk, then go to START.
REQ-019 Configuration SHALL be frozen per frame; changes mid-frame affect only the next frame.
REQ-020 Bit time SHALL be OVERSAMPLE baud_pulse ticks, counted by a tick counter that clears on every state or bit change.
REQ-021 START: tx=0 for 1 bit time, then DATA.
REQ-022 DATA: shift LSB first; bit counter runs 0..N-1 with N=5+wls; after bit N-1 go to PARITY if pen=1, else STOP.
REQ-023 Parity bit: sp=1 -> ~eps; sp=0, eps=1 -> XOR of the N data bits; sp=0, eps=0 -> XNOR of the N data bits; bits above N are excluded.
REQ-024 STOP: tx=1 for 16, 24 or 32 ticks (OVERSAMPLE=16) per REQ-009; the stop duration SHALL scale with OVERSAMPLE.
REQ-025 On the last STOP tick: if fifo_empty=0, pop and latch in that clk and go directly to START (back-to-back frames, no idle bit); otherwise go to IDLE.
REQ-026 fifo_pop SHALL never assert while fifo_empty=1, and SHALL never assert more than once per frame.
REQ-027 bc=1 SHALL force tx=0 combinationally without halting the FSM; tx returns to the FSM value on the first clk after bc falls.
REQ-028 In IDLE, tx=1 (unless bc=1); baud_pulse is ignored.
REQ-029 tx SHALL be registered (except the bc override) and glitch-free within a bit time.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: state IDLE, tx=1, fifo_pop=0, busy=0, all counters and the shift register to 0.
REQ-031 Reset mid-frame SHALL abort the frame; the popped byte is lost, and no extra pop occurs on deassertion.
REQ-032 Operation SHALL resume on the first clk after rst_n rises.

Structure
REQ-033 Shared package uart_pkg SHALL hold: the tx state enum, the wls encodings, OVERSAMPLE default, and the stop-tick constants.
REQ-034 No sub-module; the FSM, tick counter, bit counter, shift register and parity SHALL be inline in one module.

Verification
REQ-035 Scenario: wls=11, pen=0, stb=0, push 0xA5 -> one pop; tx=0, then 1,0,1,0,0,1,0,1, then 1; each bit = 16 ticks; then temt=1.
REQ-036 Scenario: wls=01, pen=1, eps=1, sp=0, byte 0x3B -> data 1,1,0,1,1,1 (6 bits), parity 1, then one stop bit.
REQ-037 Scenario: wls=00, stb=1 -> stop high 24 ticks; wls=10, stb=1 -> stop high 32 ticks.
REQ-038 Scenario: FIFO holds 0x01, 0xFF -> two pops; the second START begins on the clk after the last stop tick; busy stays 1 throughout.
REQ-039 Scenario: bc=1 mid-DATA -> tx=0 immediately, bit count unaffected; rst_n=0 mid-DATA -> tx=1, busy=0 and fifo_pop=0 asynchronously.
REQ-040 Scenario: sp=1, eps=0, pen=1 -> parity bit 1 for all data; pop never seen while fifo_empty=1 (assertion).
